// File: rtl/cross_bar_slave_mem.sv
// cross_bar_slave_mem
//   Word-addressed memory that answers one crossbar slave port. Writes complete
//   at the acceptance edge with no response. Reads return the word captured at
//   the acceptance edge as a one-cycle resp pulse RD_LAT cycles later. Only one
//   read may be outstanding at a time.
//
//   Handshake: a request transfers on a rising edge where req & ack are both 1.
//   The crossbar holds req/addr/cmd/wdata stable until it sees ack. ack is
//   combinational from the registered state and the req input.
//
// Ports
//   clk    : clock, all logic on the rising edge
//   rst_n  : synchronous active-low reset
//   req    : request valid from the crossbar
//   addr   : byte address; bits [IDX_W+1:2] select the word, the rest are ignored
//   cmd    : 0 = read, 1 = write
//   wdata  : write data
//   ack    : request accepted this cycle
//   resp   : read response valid (one-cycle pulse)
//   rdata  : read data, 0 whenever resp = 0
//
// The FSM state is held in the named signal 'state' (state_t) so that checkers
// can bind to it.
module cross_bar_slave_mem #(
  parameter int MEM_WORDS = 16,
  parameter int RD_LAT    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              resp,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(RD_LAT + 1);
  // Counter load value on a read; only meaningful when RD_LAT >= 2.
  localparam int unsigned CNT_INIT = (RD_LAT >= 2) ? RD_LAT - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_INIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] rd_q;
  logic [IDX_W-1:0]  idx;
  logic              wr_en;
  logic              rd_en;
  logic              unused_addr;

  assign idx = addr[IDX_W+1:2];
  // Byte-offset and aliasing bits are intentionally ignored.
  assign unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ack        = req & (state == IDLE) & rst_n;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (ack) begin
          if (cmd) begin
            wr_en = 1'b1;
          end else begin
            rd_en = 1'b1;
            if (RD_LAT == 1) begin
              state_next = RESP;
            end else begin
              state_next = WAIT;
              cnt_next   = CNT_LOAD;
            end
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - 1'b1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state and registered response outputs. resp/rdata are loaded for
  // the cycle in which the FSM sits in RESP. With RD_LAT = 1 the response
  // cycle directly follows the acceptance edge, so the data comes straight
  // from the array instead of from rd_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      resp  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      resp  <= (state_next == RESP);
      if (state_next == RESP) rdata <= rd_en ? mem[idx] : rd_q;
      else                    rdata <= '0;
    end
  end

  // Storage is not reset. wr_en/rd_en already include rst_n through ack.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wdata;
    if (rd_en) rd_q     <= mem[idx];
  end

endmodule

// File: tb/tb_cross_bar_slave_mem.sv
// Testbench for cross_bar_slave_mem. Two instances share one clock:
// index 0 is built with RD_LAT = 2, index 1 with RD_LAT = 1.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Every cycle is also checked against a transaction-level model.
module tb_cross_bar_slave_mem;

  localparam int MEM_WORDS = 16;

  logic clk;
  int   cyc = 0;

  logic [1:0]       rst_n_v;
  logic [1:0]       req_v;
  logic [1:0]       cmd_v;
  logic [1:0][31:0] addr_v;
  logic [1:0][31:0] wdata_v;
  logic             ack0, ack1, resp0, resp1;
  logic [31:0]      rdata0, rdata1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        req;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        ack;
    logic        resp;
    logic [31:0] rdata;
    int          cyc;
  } obs_t;

  typedef struct {
    int          k;
    int          due;
    logic [31:0] data;
    bit          known;
  } pend_t;

  // Reference model: memory image per instance, earliest acceptable cycle,
  // and the queue of expected read responses.
  logic [31:0] ref_mem   [2][MEM_WORDS];
  bit          ref_known [2][MEM_WORDS];
  int          free_at   [2];
  pend_t       exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cross_bar_slave_mem #(.MEM_WORDS(MEM_WORDS), .RD_LAT(2)) dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .req(req_v[0]), .addr(addr_v[0]),
    .cmd(cmd_v[0]), .wdata(wdata_v[0]), .ack(ack0), .resp(resp0), .rdata(rdata0)
  );

  cross_bar_slave_mem #(.MEM_WORDS(MEM_WORDS), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .req(req_v[1]), .addr(addr_v[1]),
    .cmd(cmd_v[1]), .wdata(wdata_v[1]), .ack(ack1), .resp(resp1), .rdata(rdata1)
  );

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- driver + scoreboard ----------------
  // One clock cycle on instance k: drive, sample, compare against model, advance.
  task automatic cycle(input int k, input logic r, input logic q, input logic c,
                       input logic [31:0] a, input logic [31:0] w, output obs_t o);
    int unsigned idx;
    logic        e_ack;
    logic        e_resp;
    logic [31:0] e_data;
    bit          e_known;
    rst_n_v[k] = r;
    req_v[k]   = q;
    cmd_v[k]   = c;
    addr_v[k]  = a;
    wdata_v[k] = w;
    @(negedge clk);
    o.ack   = (k == 0) ? ack0   : ack1;
    o.resp  = (k == 0) ? resp0  : resp1;
    o.rdata = (k == 0) ? rdata0 : rdata1;
    o.cyc   = cyc;

    idx     = (a >> 2) % MEM_WORDS;
    e_ack   = r && q && (cyc >= free_at[k]);
    e_resp  = 1'b0;
    e_data  = '0;
    e_known = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].k == k && exp_q[i].due == cyc) begin
        e_resp  = 1'b1;
        e_data  = exp_q[i].data;
        e_known = exp_q[i].known;
        exp_q.delete(i);
        break;
      end
    end
    chk($sformatf("m%0d_ack", k), {31'd0, o.ack}, {31'd0, e_ack});
    chk($sformatf("m%0d_resp", k), {31'd0, o.resp}, {31'd0, e_resp});
    if (!e_resp) chk($sformatf("m%0d_rdata_idle", k), o.rdata, 32'd0);
    else if (e_known) chk($sformatf("m%0d_rdata", k), o.rdata, e_data);

    if (!r) begin
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].k == k) exp_q.delete(i);
      free_at[k] = cyc + 1;
    end else if (e_ack) begin
      if (c) begin
        ref_mem[k][idx]   = w;
        ref_known[k][idx] = 1'b1;
      end else begin
        exp_q.push_back('{k: k, due: cyc + lat(k), data: ref_mem[k][idx],
                          known: ref_known[k][idx]});
        free_at[k] = cyc + lat(k) + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  vec_t tbl[15];

  initial begin
    obs_t        o;
    int          nresp;
    int          nacc;
    int          prev;
    int          cnt;
    logic        hq, hc, last_ack, r;
    logic [31:0] ha, hw;

    // Reset / aliasing directed vectors on the RD_LAT = 2 instance.
    //            rst   req   cmd   addr    wdata          ack   resp  rdata
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h08, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h11111111, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h11111111, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h11111111, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h44, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h07, 32'h0,        1'b0, 1'b1, 32'h11111111};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h07, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'h11111111};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h0};

    free_at[0] = 0;
    free_at[1] = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < MEM_WORDS; i++) begin
        ref_mem[k][i]   = '0;
        ref_known[k][i] = 1'b0;
      end

    // Initial reset of both instances; outputs are unknown before this.
    rst_n_v = 2'b00;
    req_v   = 2'b00;
    cmd_v   = 2'b00;
    addr_v  = '0;
    wdata_v = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_v[1] = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cycle(0, tbl[i].rst, tbl[i].req, tbl[i].cmd, tbl[i].addr, tbl[i].wdata, o);
      chk($sformatf("tbl%0d_ack", i), {31'd0, o.ack}, {31'd0, tbl[i].ack});
      chk($sformatf("tbl%0d_resp", i), {31'd0, o.resp}, {31'd0, tbl[i].resp});
      chk($sformatf("tbl%0d_rdata", i), o.rdata, tbl[i].rdata);
    end

    // Back-to-back writes, then readback with the request held high.
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1'b1, 1'b1, 1'b1, 32'(i * 4), 32'(i), o);
      chk("b2b_wr_ack", {31'd0, o.ack}, 32'd1);
      chk("b2b_wr_resp", {31'd0, o.resp}, 32'd0);
    end
    nresp = 0;
    nacc  = 0;
    prev  = -1;
    for (int n = 0; n < 60 && nacc < 8; n++) begin
      cycle(0, 1'b1, 1'b1, 1'b0, 32'(nacc * 4), 32'd0, o);
      if (o.resp) begin
        chk("b2b_rd_data", o.rdata, 32'(nresp));
        nresp++;
      end
      if (o.ack) begin
        if (prev >= 0) chk("b2b_rd_spacing", 32'(o.cyc - prev), 32'd3);
        prev = o.cyc;
        nacc++;
      end
    end
    for (int n = 0; n < 4; n++) begin
      cycle(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, o);
      if (o.resp) begin
        chk("b2b_rd_data", o.rdata, 32'(nresp));
        nresp++;
      end
    end
    chk("b2b_rd_count", 32'(nresp), 32'd8);

    // Reset in the cycle after a read is accepted: that read never responds.
    cycle(0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h5A5A5A5A, o);
    chk("midrd_wr_ack", {31'd0, o.ack}, 32'd1);
    cycle(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'd0, o);
    chk("midrd_rd_ack", {31'd0, o.ack}, 32'd1);
    cnt = 0;
    cycle(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, o);
    if (o.resp) cnt++;
    for (int n = 0; n < 6; n++) begin
      cycle(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, o);
      if (o.resp) cnt++;
    end
    chk("midrd_no_resp", 32'(cnt), 32'd0);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      cycle(0, 1'b1, (n == 0), 1'b0, 32'h60, 32'd0, o);
      if (o.resp) begin
        chk("midrd_new_rdata", o.rdata, 32'h5A5A5A5A);
        cnt++;
      end
    end
    chk("midrd_new_resp_count", 32'(cnt), 32'd1);
    req_v[0] = 1'b0;

    // RD_LAT = 1 instance: resp one cycle after acceptance, ack the cycle after.
    cycle(1, 1'b1, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D, o);
    chk("lat1_wr_ack", {31'd0, o.ack}, 32'd1);
    cycle(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'd0, o);
    chk("lat1_rd_ack", {31'd0, o.ack}, 32'd1);
    cycle(1, 1'b1, 1'b1, 1'b1, 32'h14, 32'd1, o);
    chk("lat1_busy_ack", {31'd0, o.ack}, 32'd0);
    chk("lat1_resp", {31'd0, o.resp}, 32'd1);
    chk("lat1_rdata", o.rdata, 32'hCAFEF00D);
    cycle(1, 1'b1, 1'b1, 1'b1, 32'h14, 32'd1, o);
    chk("lat1_reack", {31'd0, o.ack}, 32'd1);
    chk("lat1_resp_end", {31'd0, o.resp}, 32'd0);

    // Random traffic on both builds; unacked requests are held stable.
    for (int k = 0; k < 2; k++) begin
      hq       = 1'b0;
      hc       = 1'b0;
      ha       = '0;
      hw       = '0;
      last_ack = 1'b0;
      for (int n = 0; n < 400; n++) begin
        if (!(hq && !last_ack)) begin
          hq = ($urandom_range(0, 9) < 7);
          hc = 1'($urandom_range(0, 1));
          ha = $urandom_range(0, 255);
          hw = $urandom;
        end
        r = ($urandom_range(0, 63) != 0);
        cycle(k, r, hq, hc, ha, hw, o);
        last_ack = o.ack;
      end
      for (int n = 0; n < 4; n++) cycle(k, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, o);
    end
    chk("no_lost_responses", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
